nand_apb_ctrl: RTL and testbench
================================

# nand_apb_ctrl

Parametrised APB-slave NAND flash controller, successor to the fixed 8-bit single-chip controller. Software issues individual command-latch, address-latch, data-write and data-read bus cycles through APB registers. The block sequences nCE/CLE/ALE/nWE/nRE/IO with programmable pulse widths and supports an 8- or 16-bit IO bus and up to 4 chip enables. It can also wait on the device ready/busy line with a timeout. It sits between the processor APB fabric and the NAND device pins.

## Interface
- IO_W, 8, NAND IO width; 8 or 16 only
- NUM_CE, 1, number of chip enables; 1..4
- TWP, 2, nWE low width in PCLK cycles; min 1
- TWH, 2, nWE high hold after low phase, cycles; min 1
- TRP, 2, nRE low width, cycles; min 1
- TREH, 2, nRE high hold, cycles; min 1
- TWB, 8, cycles after a wait-flagged command before nRB is sampled
- TOUT, 65535, ready-wait timeout in cycles; 1..65535

- PCLK  in  1  clock; all logic on rising edge
- PRESETN  in  1  asynchronous active-low reset
- PADDR  in  5  byte address; word index PADDR[4:2], PADDR[1:0] ignored
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  always 1 (zero wait states)
- PSLVERR  out  1  error response, valid in access phase
- nCE  out  NUM_CE  chip enables, active low
- CLE, ALE  out  1 each  command/address latch enables
- nWE, nRE  out  1 each  write/read strobes, active low
- nWP  out  1  write protect, active low
- IO_O  out  IO_W  IO drive value
- IO_OE  out  1  IO output enable (pad tristate control)
- IO_I  in  IO_W  IO pad input
- nRB  in  1  device ready/busy, asynchronous, low = busy

## Operation
- Access phase: PSEL & PENABLE; writes take effect on that edge.
- Register map, byte offsets:
  - 0x00 CMD (W): [7:0] command, [8] wait_rb. Starts a command cycle.
  - 0x04 ADDR (W): [7:0] address. Starts an address cycle.
  - 0x08 DATA: write [IO_W-1:0] starts a data-write cycle; read returns the last captured read data, zero-extended.
  - 0x0C RDTRIG (W, data ignored): starts a data-read cycle.
  - 0x10 CFG (RW): [1:0] ce_sel, [4] ce_en, [5] wp_n. Reset 0.
  - 0x14 STATUS: read returns [0] busy, [1] rb_sync, [2] timeout (sticky). Any write clears timeout.
- PSLVERR=1 in the following cases; the access is otherwise ignored:
  - unmapped offset (0x18–0x1C)
  - trigger write (0x00/0x04/0x08/0x0C) while busy
  - read of DATA while busy
  - read of 0x00, 0x04 or 0x0C (these also return 0)
- Chip enable: nCE[i] = ~(ce_en & ce_sel==i). If ce_sel ≥ NUM_CE, all nCE are high. nWP = wp_n.
- nRB passes through a 2-flop synchroniser to give rb_sync.
- FSM states: IDLE, SETUP, LOW, HIGH, WAITB, WAITRB.
  - IDLE → SETUP on an accepted trigger. busy = (state != IDLE).
  - SETUP, 1 cycle:
    - CLE=1 for CMD; ALE=1 for ADDR.
    - Write types: IO_O = byte/word, IO_OE=1.
    - Read: IO_OE=0.
  - LOW:
    - Write types: nWE=0 for TWP cycles.
    - Read: nRE=0 for TRP cycles.
    - Read data is captured from IO_I on the edge ending the last LOW cycle.
  - HIGH: strobe high; CLE/ALE/IO_O/IO_OE held for TWH cycles (read: TREH). Then:
    - → WAITB if CMD with wait_rb=1
    - otherwise → IDLE
  - WAITB: TWB cycles, then → WAITRB.
  - WAITRB:
    - → IDLE when rb_sync=1.
    - If TOUT cycles elapse first: set timeout, → IDLE.
  - On entering IDLE: CLE=ALE=0, IO_OE=0.
- CFG writes while busy are accepted and take effect immediately.
- Command and address cycles are always 8-bit. For IO_W=16, the upper IO_O bits are 0 during those cycles.

## Timing
- Reset values:
  - nCE all 1; CLE=ALE=0; nWE=nRE=1; nWP=0
  - IO_O=0; IO_OE=0
  - PRDATA=0; PREADY=1; PSLVERR=0
  - state IDLE; all registers 0
- PRDATA and PSLVERR are combinational from the access-phase decode.
- Trigger accepted at edge N: busy reads 1 from cycle N+1; SETUP occupies cycle N+1.
- Write-type cycle busy duration: 1+TWP+TWH cycles (default 5).
- Read cycle busy duration: 1+TRP+TREH cycles. DATA is valid once busy=0.
- Wait command adds TWB + the nRB wait (≥ 1 + 2 synchroniser cycles).
- Back-to-back triggers: software polls busy; there is no queue.
- Reset asserted mid-cycle: all outputs go to reset values asynchronously; the transaction is abandoned.

## Test plan
- Reset mid-LOW of a write → nWE=1, IO_OE=0 and nCE all 1 immediately; STATUS=0 after release.
- CFG=0x30, CMD=0x0FF → nCE[0]=0, nWP=1, CLE high 5 cycles, nWE low exactly 2 cycles with IO_O=0xFF, busy drops after 5 cycles.
- ADDR=0x12 then DATA write 0xA5 (IO_W=8) → ALE cycle with 0x12, then data cycle with ALE=CLE=0 and IO_O=0xA5.
- IO_W=16: IO_I=0xBEEF, RDTRIG → nRE low 2 cycles, IO_OE=0; DATA read returns 0x0000BEEF.
- CMD=0x130 (wait_rb), nRB low 20 cycles → busy held until 2 cycles after nRB rises. With TOUT=50 and nRB held low → timeout=1, busy=0; write STATUS clears it.
- Trigger write while busy, access to 0x18, and ce_sel=3 with NUM_CE=2 → PSLVERR=1 with FSM unaffected, PSLVERR=1, and nCE=2'b11, respectively.

Source files
------------

// File: rtl/nand_apb_ctrl_if.sv
// APB slave-side bus bundle for the NAND controller: address/control from
// the fabric, read data and response back to it.
`timescale 1ns/1ps
interface nand_apb_ctrl_if;
  logic [4:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/nand_apb_ctrl.sv
// APB-slave NAND flash controller. Software issues single command, address,
// data-write and data-read bus cycles through registers; the block sequences
// the NAND strobes with programmable pulse widths and can wait on ready/busy
// with a timeout. IO bus is 8 or 16 bits, up to four chip enables.
`timescale 1ns/1ps
module nand_apb_ctrl #(
  parameter int IO_W   = 8,
  parameter int NUM_CE = 1,
  parameter int TWP    = 2,
  parameter int TWH    = 2,
  parameter int TRP    = 2,
  parameter int TREH   = 2,
  parameter int TWB    = 8,
  parameter int TOUT   = 65535
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  nand_apb_ctrl_if.slave    apb,
  output logic [NUM_CE-1:0] nCE,
  output logic              CLE,
  output logic              ALE,
  output logic              nWE,
  output logic              nRE,
  output logic              nWP,
  output logic [IO_W-1:0]   IO_O,
  output logic              IO_OE,
  input  logic [IO_W-1:0]   IO_I,
  input  logic              nRB
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_LOW    = 3'd2;
  localparam logic [2:0] ST_HIGH   = 3'd3;
  localparam logic [2:0] ST_WAITB  = 3'd4;
  localparam logic [2:0] ST_WAITRB = 3'd5;

  // Operation codes deliberately equal the register word index of the trigger
  localparam logic [1:0] OP_CMD  = 2'd0;
  localparam logic [1:0] OP_ADDR = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;
  localparam logic [1:0] OP_RD   = 2'd3;

  localparam logic [15:0] TWP_LAST  = 16'(TWP - 1);
  localparam logic [15:0] TWH_LAST  = 16'(TWH - 1);
  localparam logic [15:0] TRP_LAST  = 16'(TRP - 1);
  localparam logic [15:0] TREH_LAST = 16'(TREH - 1);
  localparam logic [15:0] TWB_LAST  = 16'(TWB - 1);
  localparam logic [15:0] TOUT_LAST = 16'(TOUT - 1);

  logic [2:0]      state;
  logic [1:0]      op;
  logic            wait_rb;
  logic [15:0]     cnt;
  logic [IO_W-1:0] rd_data;
  logic [1:0]      ce_sel;
  logic            ce_en;
  logic            wp_n;
  logic            timeout;
  logic            rb_meta;
  logic            rb_sync;

  logic            access;
  logic [2:0]      word;
  logic            busy;
  logic            is_rd;
  logic            trig;
  logic            to_fire;
  logic            cfg_wr;
  logic            status_wr;
  logic [31:0]     rdata;
  logic            slverr;
  logic            unused_bits;

  assign access    = apb.PSEL & apb.PENABLE;
  assign word      = apb.PADDR[4:2];
  assign busy      = (state != ST_IDLE);
  assign is_rd     = (op == OP_RD);
  assign trig      = access & apb.PWRITE & (word <= 3'd3) & ~busy;
  assign cfg_wr    = access & apb.PWRITE & (word == 3'd4);
  assign status_wr = access & apb.PWRITE & (word == 3'd5);
  assign to_fire   = (state == ST_WAITRB) & ~rb_sync & (cnt == TOUT_LAST);

  assign apb.PREADY  = 1'b1;
  assign apb.PRDATA  = rdata;
  assign apb.PSLVERR = slverr;
  assign nWP         = wp_n;
  assign unused_bits = ^{apb.PWDATA, apb.PADDR[1:0]};

  // Access-phase decode: read mux and error response, both combinational
  always_comb begin
    rdata  = '0;
    slverr = 1'b0;
    if (access) begin
      if (word > 3'd5) begin
        slverr = 1'b1;
      end else if (apb.PWRITE) begin
        if ((word <= 3'd3) && busy) slverr = 1'b1;
      end else begin
        case (word)
          3'd2: begin
            if (busy) slverr = 1'b1;
            else      rdata  = 32'(rd_data);
          end
          3'd4:    rdata  = {26'd0, wp_n, ce_en, 2'd0, ce_sel};
          3'd5:    rdata  = {29'd0, timeout, rb_sync, busy};
          default: slverr = 1'b1;
        endcase
      end
    end
  end

  // Chip enables decode from configuration; out-of-range select leaves all high
  always_comb begin
    for (int i = 0; i < NUM_CE; i++) begin
      nCE[i] = ~(ce_en & (ce_sel == 2'(i)));
    end
  end

  // Configuration register, writable at any time including mid-transaction
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ce_sel <= 2'd0;
      ce_en  <= 1'b0;
      wp_n   <= 1'b0;
    end else if (cfg_wr) begin
      ce_sel <= apb.PWDATA[1:0];
      ce_en  <= apb.PWDATA[4];
      wp_n   <= apb.PWDATA[5];
    end
  end

  // Two-flop synchroniser for the asynchronous ready/busy pin
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rb_meta <= 1'b0;
      rb_sync <= 1'b0;
    end else begin
      rb_meta <= nRB;
      rb_sync <= rb_meta;
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)       timeout <= 1'b0;
    else if (to_fire)   timeout <= 1'b1;
    else if (status_wr) timeout <= 1'b0;
  end

  // Bus-cycle sequencer: drives the NAND pins and captures read data
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state   <= ST_IDLE;
      op      <= OP_CMD;
      wait_rb <= 1'b0;
      cnt     <= '0;
      CLE     <= 1'b0;
      ALE     <= 1'b0;
      nWE     <= 1'b1;
      nRE     <= 1'b1;
      IO_O    <= '0;
      IO_OE   <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            state   <= ST_SETUP;
            op      <= word[1:0];
            wait_rb <= (word == 3'd0) & apb.PWDATA[8];
            cnt     <= '0;
            CLE     <= (word == 3'd0);
            ALE     <= (word == 3'd1);
            IO_OE   <= (word != 3'd3);
            case (word[1:0])
              OP_CMD, OP_ADDR: IO_O <= IO_W'(apb.PWDATA[7:0]);
              OP_WR:           IO_O <= apb.PWDATA[IO_W-1:0];
              default:         IO_O <= '0;
            endcase
          end
        end
        ST_SETUP: begin
          state <= ST_LOW;
          cnt   <= '0;
          if (is_rd) nRE <= 1'b0;
          else       nWE <= 1'b0;
        end
        ST_LOW: begin
          if (cnt == (is_rd ? TRP_LAST : TWP_LAST)) begin
            state <= ST_HIGH;
            cnt   <= '0;
            nWE   <= 1'b1;
            nRE   <= 1'b1;
            if (is_rd) rd_data <= IO_I;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_HIGH: begin
          if (cnt == (is_rd ? TREH_LAST : TWH_LAST)) begin
            cnt <= '0;
            if ((op == OP_CMD) && wait_rb) begin
              state <= ST_WAITB;
            end else begin
              state <= ST_IDLE;
              CLE   <= 1'b0;
              ALE   <= 1'b0;
              IO_OE <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAITB: begin
          if (cnt == TWB_LAST) begin
            state <= ST_WAITRB;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAITRB: begin
          if (rb_sync || (cnt == TOUT_LAST)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            CLE   <= 1'b0;
            ALE   <= 1'b0;
            IO_OE <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          CLE   <= 1'b0;
          ALE   <= 1'b0;
          IO_OE <= 1'b0;
          nWE   <= 1'b1;
          nRE   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_apb_ctrl.sv
// Self-checking bench for nand_apb_ctrl (16-bit IO, two chip enables,
// short ready timeout). Expected pin activity is derived from the register
// rules and pulse-width parameters, not from the controller's internals.
`timescale 1ns/1ps
module tb_nand_apb_ctrl;
  localparam int IO_W = 16, NUM_CE = 2, TWP = 2, TWH = 2, TRP = 2, TREH = 2;
  localparam int TWB = 8, TOUT = 50;
  localparam logic [4:0] A_CMD = 5'h00, A_ADDR = 5'h04, A_DATA = 5'h08;
  localparam logic [4:0] A_RDT = 5'h0C, A_CFG = 5'h10, A_STAT = 5'h14;

  logic              PCLK = 1'b0;
  logic              PRESETN;
  logic [NUM_CE-1:0] nCE;
  logic              CLE, ALE, nWE, nRE, nWP, IO_OE;
  logic [IO_W-1:0]   IO_O, IO_I;
  logic              nRB;
  int                passed = 0;
  int                total = 0;

  nand_apb_ctrl_if bus();

  nand_apb_ctrl #(
    .IO_W(IO_W), .NUM_CE(NUM_CE), .TWP(TWP), .TWH(TWH), .TRP(TRP),
    .TREH(TREH), .TWB(TWB), .TOUT(TOUT)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .apb(bus),
    .nCE(nCE), .CLE(CLE), .ALE(ALE), .nWE(nWE), .nRE(nRE), .nWP(nWP),
    .IO_O(IO_O), .IO_OE(IO_OE), .IO_I(IO_I), .nRB(nRB)
  );

  always #5 PCLK = ~PCLK;

  // Reference timing: busy cycles of one write- or read-type bus cycle
  function automatic int ref_busy(input bit rd);
    return rd ? (1 + TRP + TREH) : (1 + TWP + TWH);
  endfunction

  function automatic logic [1:0] ref_nce(input int sel, input bit en);
    logic [1:0] v;
    for (int i = 0; i < NUM_CE; i++) v[i] = !(en && (sel == i));
    return v;
  endfunction

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    d = bus.PRDATA; err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Called right after a trigger edge: polls STATUS every cycle while
  // counting pin activity; done is the first cycle busy reads 0 (-1 if never).
  // nRB is released at cycle rise_at when rise_at > 0.
  task automatic watch(input int rise_at, output int done, output int cle_n, output int ale_n,
                       output int nwe_n, output int nre_n, output int oe_n,
                       output logic [15:0] io_we);
    bit fin;
    done = -1; cle_n = 0; ale_n = 0; nwe_n = 0; nre_n = 0; oe_n = 0; io_we = 'x; fin = 0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = A_STAT;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge PCLK);
      if (CLE) cle_n++;
      if (ALE) ale_n++;
      if (IO_OE) oe_n++;
      if (!nRE) nre_n++;
      if (!nWE) begin
        if (nwe_n == 0) io_we = IO_O;
        nwe_n++;
      end
      if (cyc >= 2 && bus.PRDATA[0] == 1'b0) begin
        done = cyc; fin = 1;
      end
      if (cyc == rise_at) nRB = 1'b1;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic err; logic [31:0] d; bit seen;
    PRESETN = 1'b0; nRB = 1'b0; IO_I = '0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    #12;
    total++;
    if ({nCE, CLE, ALE, nWE, nRE, nWP, IO_OE} !== 8'b11_0_0_1_1_0_0) begin
      $display("[TB] FAIL reset_pins: got %b expected 11001100", {nCE, CLE, ALE, nWE, nRE, nWP, IO_OE});
    end else passed++;
    total++;
    if (IO_O !== 16'h0) $display("[TB] FAIL reset_io: got %h expected 0000", IO_O);
    else passed++;
    total++;
    if ({bus.PREADY, bus.PSLVERR, bus.PRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      $display("[TB] FAIL reset_apb: got %b/%b/%h expected 1/0/0", bus.PREADY, bus.PSLVERR, bus.PRDATA);
    end else passed++;
    @(negedge PCLK); PRESETN = 1'b1;
    apb_read(A_STAT, d, err);
    total++;
    if ({err, d} !== 33'h0) $display("[TB] FAIL reset_status: got %b/%h expected 0/0", err, d);
    else passed++;
    // Abort a command in its nWE low phase
    apb_write(A_CFG, 32'h30, err);
    apb_write(A_CMD, 32'h0FF, err);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge PCLK);
      if (!nWE) seen = 1;
    end
    total++;
    if (!seen) $display("[TB] FAIL midlow_nwe_seen: got 0 expected 1");
    else passed++;
    #2 PRESETN = 1'b0;
    #1;
    total++;
    if ({nWE, IO_OE, nCE, CLE, nWP} !== 6'b1_0_11_0_0) begin
      $display("[TB] FAIL midlow_reset_pins: got %b expected 101100", {nWE, IO_OE, nCE, CLE, nWP});
    end else passed++;
    @(negedge PCLK); PRESETN = 1'b1;
    apb_read(A_STAT, d, err);
    total++;
    if (d !== 32'h0) $display("[TB] FAIL midlow_status: got %h expected 0", d);
    else passed++;
    apb_read(A_CFG, d, err);
    total++;
    if (d !== 32'h0) $display("[TB] FAIL midlow_cfg: got %h expected 0", d);
    else passed++;
  endtask

  task automatic test_command();
    logic err; int done, cle_n, ale_n, nwe_n, nre_n, oe_n; logic [15:0] io;
    nRB = 1'b1;
    apb_write(A_CFG, 32'h30, err);
    total++;
    if ({nCE, nWP} !== 3'b10_1) $display("[TB] FAIL cfg30_pins: got %b expected 101", {nCE, nWP});
    else passed++;
    apb_write(A_CMD, 32'h0FF, err);
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if (cle_n !== 5 || ale_n !== 0) $display("[TB] FAIL cmd_cle: got cle=%0d ale=%0d expected 5/0", cle_n, ale_n);
    else passed++;
    total++;
    if (nwe_n !== TWP) $display("[TB] FAIL cmd_nwe_width: got %0d expected %0d", nwe_n, TWP);
    else passed++;
    total++;
    if (io !== 16'h00FF) $display("[TB] FAIL cmd_io: got %h expected 00ff", io);
    else passed++;
    total++;
    if (done !== ref_busy(0) + 1) $display("[TB] FAIL cmd_busy_end: got %0d expected %0d", done, ref_busy(0) + 1);
    else passed++;
    // Upper IO bits stay zero on 8-bit command cycles
    apb_write(A_CMD, 32'hF0FE, err);
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if (io !== 16'h00FE) $display("[TB] FAIL cmd_io_upper: got %h expected 00fe", io);
    else passed++;
  endtask

  task automatic test_addr_data();
    logic err; int done, cle_n, ale_n, nwe_n, nre_n, oe_n; logic [15:0] io;
    apb_write(A_ADDR, 32'h12, err);
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if ({8'(ale_n), 8'(cle_n), io} !== {8'd5, 8'd0, 16'h0012}) begin
      $display("[TB] FAIL addr_cycle: got ale=%0d cle=%0d io=%h expected 5/0/0012", ale_n, cle_n, io);
    end else passed++;
    apb_write(A_DATA, 32'hA5, err);
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if ({8'(ale_n), 8'(cle_n), 8'(nwe_n), io} !== {8'd0, 8'd0, 8'(TWP), 16'h00A5}) begin
      $display("[TB] FAIL data_cycle: got ale=%0d cle=%0d nwe=%0d io=%h expected 0/0/2/00a5", ale_n, cle_n, nwe_n, io);
    end else passed++;
  endtask

  task automatic test_read();
    logic err; logic [31:0] d; int done, cle_n, ale_n, nwe_n, nre_n, oe_n; logic [15:0] io;
    IO_I = 16'hBEEF;
    apb_write(A_RDT, 32'h0, err);
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if ({8'(nre_n), 8'(oe_n), 8'(nwe_n), 8'(done)} !== {8'(TRP), 8'd0, 8'd0, 8'(ref_busy(1) + 1)}) begin
      $display("[TB] FAIL read_cycle: got nre=%0d oe=%0d nwe=%0d done=%0d expected %0d/0/0/%0d",
               nre_n, oe_n, nwe_n, done, TRP, ref_busy(1) + 1);
    end else passed++;
    IO_I = 16'h0;
    apb_read(A_DATA, d, err);
    total++;
    if ({err, d} !== {1'b0, 32'h0000BEEF}) $display("[TB] FAIL read_data: got %b/%h expected 0/0000beef", err, d);
    else passed++;
  endtask

  task automatic test_wait_rb();
    logic err; logic [31:0] d; int done, cle_n, ale_n, nwe_n, nre_n, oe_n, rise, expv, first_wrb;
    logic [15:0] io;
    first_wrb = ref_busy(0) + TWB + 1;
    nRB = 1'b0;
    apb_write(A_CMD, 32'h130, err);
    watch(20, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if (done !== 23) $display("[TB] FAIL wait_rb_directed: got %0d expected 23", done);
    else passed++;
    apb_read(A_STAT, d, err);
    total++;
    if (d !== 32'h2) $display("[TB] FAIL wait_rb_status: got %h expected 2", d);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      rise = int'($urandom_range(5, 40));
      expv = (((rise + 2) > first_wrb) ? (rise + 2) : first_wrb) + 1;
      nRB = 1'b0;
      apb_write(A_CMD, 32'h100 | 32'($urandom_range(0, 255)), err);
      watch(rise, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
      total++;
      if (done !== expv) $display("[TB] FAIL wait_rb_random: rise=%0d got %0d expected %0d", rise, done, expv);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic err; logic [31:0] d; int done, cle_n, ale_n, nwe_n, nre_n, oe_n; logic [15:0] io;
    nRB = 1'b0;
    apb_write(A_CMD, 32'h1AB, err);
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if (done !== ref_busy(0) + TWB + TOUT + 1) begin
      $display("[TB] FAIL timeout_busy_end: got %0d expected %0d", done, ref_busy(0) + TWB + TOUT + 1);
    end else passed++;
    apb_read(A_STAT, d, err);
    total++;
    if (d !== 32'h4) $display("[TB] FAIL timeout_status: got %h expected 4", d);
    else passed++;
    apb_write(A_STAT, 32'h0, err);
    apb_read(A_STAT, d, err);
    total++;
    if (d !== 32'h0) $display("[TB] FAIL timeout_clear: got %h expected 0", d);
    else passed++;
    nRB = 1'b1;
  endtask

  task automatic test_errors();
    logic err; logic [31:0] d; int done, cle_n, ale_n, nwe_n, nre_n, oe_n; logic [15:0] io;
    logic [4:0] wo [3];
    wo[0] = A_CMD; wo[1] = A_ADDR; wo[2] = A_RDT;
    // Trigger while busy is refused and the running command is untouched
    apb_write(A_CMD, 32'h0AA, err);
    apb_write(A_ADDR, 32'h55, err);
    total++;
    if (err !== 1'b1) $display("[TB] FAIL busy_trigger_err: got %b expected 1", err);
    else passed++;
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if ({8'(cle_n), 8'(ale_n), 8'(done)} !== {8'd2, 8'd0, 8'd3}) begin
      $display("[TB] FAIL busy_trigger_fsm: got cle=%0d ale=%0d done=%0d expected 2/0/3", cle_n, ale_n, done);
    end else passed++;
    apb_write(A_CMD, 32'h0AA, err);
    apb_read(A_DATA, d, err);
    total++;
    if (err !== 1'b1) $display("[TB] FAIL busy_data_read_err: got %b expected 1", err);
    else passed++;
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    // CFG is accepted mid-transaction and takes effect at once
    apb_write(A_CMD, 32'h0AA, err);
    apb_write(A_CFG, 32'h31, err);
    total++;
    if ({err, nCE, nWP} !== 4'b0_01_1) $display("[TB] FAIL busy_cfg: got %b expected 0011", {err, nCE, nWP});
    else passed++;
    watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
    total++;
    if (done !== 3) $display("[TB] FAIL busy_cfg_done: got %0d expected 3", done);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      apb_read(wo[k], d, err);
      total++;
      if ({err, d} !== {1'b1, 32'h0}) $display("[TB] FAIL wo_read_%0h: got %b/%h expected 1/0", wo[k], err, d);
      else passed++;
    end
    apb_write(5'h18, 32'h0, err);
    total++;
    if (err !== 1'b1) $display("[TB] FAIL unmapped_write: got %b expected 1", err);
    else passed++;
    apb_read(5'h1C, d, err);
    total++;
    if (err !== 1'b1) $display("[TB] FAIL unmapped_read: got %b expected 1", err);
    else passed++;
    apb_write(A_CFG, 32'h13, err);
    total++;
    if (nCE !== 2'b11) $display("[TB] FAIL ce_sel_out_of_range: got %b expected 11", nCE);
    else passed++;
    apb_read(A_CFG, d, err);
    total++;
    if (d !== 32'h13) $display("[TB] FAIL cfg_readback: got %h expected 13", d);
    else passed++;
  endtask

  task automatic test_random();
    logic err; logic [31:0] d, rd, iod, cfgw; int done, cle_n, ale_n, nwe_n, nre_n, oe_n, sel, op, dur;
    bit en, wp; logic [15:0] io, exp_io; logic [47:0] got, expv;
    for (int it = 0; it < 16; it++) begin
      sel = int'($urandom_range(0, 3)); en = 1'($urandom_range(0, 1)); wp = 1'($urandom_range(0, 1));
      cfgw = {26'd0, wp, en, 2'd0, 2'(sel)};
      apb_write(A_CFG, cfgw, err);
      total++;
      if ({nCE, nWP} !== {ref_nce(sel, en), wp}) begin
        $display("[TB] FAIL rand_cfg_pins: cfg=%h got %b expected %b", cfgw, {nCE, nWP}, {ref_nce(sel, en), wp});
      end else passed++;
      op = int'($urandom_range(0, 3));
      d = $urandom;
      if (op == 0) d[8] = 1'b0;
      iod = $urandom;
      IO_I = iod[15:0];
      apb_write(5'(op << 2), d, err);
      total++;
      if (err !== 1'b0) $display("[TB] FAIL rand_trigger_err: op=%0d got %b expected 0", op, err);
      else passed++;
      watch(0, done, cle_n, ale_n, nwe_n, nre_n, oe_n, io);
      dur = ref_busy(op == 3);
      got  = {8'(cle_n), 8'(ale_n), 8'(nwe_n), 8'(nre_n), 8'(oe_n), 8'(done)};
      expv = {8'(op == 0 ? dur : 0), 8'(op == 1 ? dur : 0), 8'(op != 3 ? TWP : 0),
              8'(op == 3 ? TRP : 0), 8'(op != 3 ? dur : 0), 8'(dur + 1)};
      total++;
      if (got !== expv) $display("[TB] FAIL rand_pin_counts: op=%0d got %h expected %h", op, got, expv);
      else passed++;
      if (op != 3) begin
        exp_io = (op == 2) ? d[15:0] : {8'h00, d[7:0]};
        total++;
        if (io !== exp_io) $display("[TB] FAIL rand_io: op=%0d got %h expected %h", op, io, exp_io);
        else passed++;
      end else begin
        apb_read(A_DATA, rd, err);
        total++;
        if (rd !== {16'h0, iod[15:0]}) $display("[TB] FAIL rand_read_data: got %h expected %h", rd, {16'h0, iod[15:0]});
        else passed++;
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_command();
    test_addr_data();
    test_read();
    test_wait_rb();
    test_timeout();
    test_errors();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
